// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready pipeline register with optional 2-entry skid buffer, flush, bubble insert and bubble counter
module pipe_stage_elastic #(
  parameter int DATA_W = 197,
  parameter int CTRL_W = 5,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CLR,
  input  logic              bb,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bub_cnt
);
  localparam int W = DATA_W + CTRL_W;
  logic [W-1:0] head, skid, stored, head_n, skid_n;
  logic [1:0] occ, occ_n;
  logic acc, emit;
  assign stored    = bb ? '0 : {in_data, in_ctrl};
  assign out_valid = occ != 2'd0;
  assign in_ready  = (SKID != 0) ? (occ != 2'd2) : (~out_valid | out_ready);
  assign acc       = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  assign out_data  = head[W-1:CTRL_W];
  assign out_ctrl  = head[CTRL_W-1:0];
  assign occupancy = occ;
  always_comb begin
    occ_n  = occ;
    head_n = head;
    skid_n = skid;
    if (CLR) begin
      occ_n  = 2'd0;
      head_n = '0;
      skid_n = '0;
    end else if (occ == 2'd2) begin
      if (emit) begin
        occ_n  = 2'd1;
        head_n = skid;
        skid_n = '0;
      end
    end else if (acc && (occ == 2'd0 || emit)) begin
      occ_n  = 2'd1;
      head_n = stored;
    end else if (acc) begin
      occ_n  = 2'd2;
      skid_n = stored;
    end else if (emit) begin
      occ_n  = 2'd0;
      head_n = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      occ     <= 2'd0;
      head    <= '0;
      skid    <= '0;
      bub_cnt <= '0;
    end else begin
      occ  <= occ_n;
      head <= head_n;
      skid <= skid_n;
      if (acc && bb && !CLR && !(&bub_cnt)) bub_cnt <= bub_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: scoreboard bench for the elastic stage, plus SKID=0/CNT_W=2 corner instance
module tb_pipe_stage_elastic;
  localparam int DW = 197, CW = 5;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, clr, bb, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0] occupancy;
  logic [15:0] bub_cnt;
  logic clr2, bb2, in_valid2, in_ready2, out_valid2, out_ready2;
  logic [7:0] in_data2, out_data2;
  logic [4:0] in_ctrl2, out_ctrl2;
  logic [1:0] occupancy2;
  logic [1:0] bub_cnt2;
  int checks = 0, failures = 0;
  logic [DW+CW-1:0] q[$];
  pipe_stage_elastic dut (
    .clk(clk), .rst(rst), .CLR(clr), .bb(bb),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .bub_cnt(bub_cnt)
  );
  pipe_stage_elastic #(.DATA_W(8), .CTRL_W(5), .SKID(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .CLR(clr2), .bb(bb2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_ctrl(in_ctrl2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_ctrl(out_ctrl2),
    .occupancy(occupancy2), .bub_cnt(bub_cnt2)
  );
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c, input logic b);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
    bb       = b;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_extra actual=%0h required=none", {out_data, out_ctrl});
        end else chk("sb_data", {out_data, out_ctrl}, q.pop_front());
      end
      if (!out_valid) chk("idle_zero", {out_data, out_ctrl}, 0);
      if (clr) q.delete();
      else if (in_valid && in_ready) q.push_back(bb ? '0 : {in_data, in_ctrl});
    end
  end
  initial begin
    rst = 1; clr = 0; out_ready = 1;
    drive(1, 'h77, 5'h3, 0);
    clr2 = 0; bb2 = 0; in_valid2 = 0; in_data2 = 0; in_ctrl2 = 0; out_ready2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("t1_valid", out_valid, 0);
    chk("t1_out", {out_data, out_ctrl}, 0);
    chk("t1_occ", occupancy, 0);
    chk("t1_bub", bub_cnt, 0);
    rst = 0;
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("t1_in_ready", in_ready, 1);
    cyc();
    for (int i = 1; i <= 8; i++) begin
      drive(1, DW'(i), CW'(i), 0);
      @(negedge clk);
      chk("t2_occ", occupancy, (i > 1) ? 1 : 0);
      if (i > 1) chk("t2_latency", out_data, i - 1);
      cyc();
    end
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("t2_last", out_data, 8);
    cyc();
    @(negedge clk);
    chk("t2_empty", occupancy, 0);
    out_ready = 0;
    drive(1, 'hA, 5'h1, 0);
    cyc();
    drive(1, 'hB, 5'h2, 0);
    cyc();
    drive(1, 'hC, 5'h3, 0);
    @(negedge clk);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_occ", occupancy, 2);
    chk("t3_head", out_data, 'hA);
    cyc();
    @(negedge clk);
    chk("t3_hold", {out_data, out_ctrl}, {DW'('hA), 5'h1});
    chk("t3_stall", in_ready, 0);
    cyc();
    out_ready = 1;
    cyc();
    @(negedge clk);
    chk("t3_release_ready", in_ready, 1);
    chk("t3_release_occ", occupancy, 1);
    chk("t3_release_head", out_data, 'hB);
    cyc();
    drive(0, 0, 0, 0);
    cyc();
    @(negedge clk);
    chk("t3_drained", occupancy, 0);
    drive(1, 'h5, 5'b10001, 1);
    cyc();
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("t4_valid", out_valid, 1);
    chk("t4_zero", {out_data, out_ctrl}, 0);
    chk("t4_bub", bub_cnt, 1);
    bb = 1;
    cyc();
    bb = 0;
    @(negedge clk);
    chk("t4_bub_noacc", bub_cnt, 1);
    out_ready = 0;
    drive(1, 'h21, 5'h4, 0);
    cyc();
    drive(1, 'h22, 5'h5, 0);
    cyc();
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("t5_full", occupancy, 2);
    cyc();
    clr = 1; out_ready = 1;
    drive(1, 'h23, 5'h6, 1);
    cyc();
    clr = 0; out_ready = 0;
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("t5_occ", occupancy, 0);
    chk("t5_valid", out_valid, 0);
    chk("t5_bub", bub_cnt, 1);
    drive(1, 'h24, 5'h7, 0);
    cyc();
    clr = 1; out_ready = 1;
    drive(1, 'h25, 5'h8, 1);
    cyc();
    clr = 0;
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("t5b_occ", occupancy, 0);
    chk("t5b_bub", bub_cnt, 1);
    repeat (3) cyc();
    chk("sb_drain", q.size(), 0);
    in_valid2 = 1; in_data2 = 8'h31; in_ctrl2 = 5'h1;
    cyc();
    in_data2 = 8'h32; in_ctrl2 = 5'h2;
    @(negedge clk);
    chk("t6_ready_low", in_ready2, 0);
    chk("t6_occ", occupancy2, 1);
    chk("t6_head", out_data2, 8'h31);
    cyc();
    out_ready2 = 1;
    @(negedge clk);
    chk("t6_ready_high", in_ready2, 1);
    cyc();
    @(negedge clk);
    chk("t6_next", {out_data2, out_ctrl2}, {8'h32, 5'h2});
    chk("t6_occ_max", occupancy2, 1);
    bb2 = 1;
    repeat (5) cyc();
    in_valid2 = 0; bb2 = 0;
    @(negedge clk);
    chk("t6_bub_sat", bub_cnt2, 3);
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
